// File: rtl/display_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with tear-free frame reload.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            nibble_out,
  output logic [DIGITS-1:0]     an_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_sh_data;
  logic [DIGITS-1:0]     r_sh_dp;
  logic [4*DIGITS-1:0]   r_disp_data;
  logic [DIGITS-1:0]     r_disp_dp;
  logic [3:0]            r_nib;
  logic [DIGITS-1:0]     r_an_n;
  logic                  r_dp_n;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_wrap;
  logic [IW-1:0]         w_idx_nx;
  logic [4*DIGITS-1:0]   w_src_data;
  logic [DIGITS-1:0]     w_src_dp;
  logic [DIGITS-1:0]     w_blank;
  logic [DIGITS-1:0]     w_one;
  logic [3:0]            w_nib;
  logic                  w_sel_blank;
  logic                  w_sel_dp;

  assign w_tick   = (r_cnt == CNT_LAST);
  assign w_wrap   = w_tick && (r_idx == IDX_LAST);
  assign w_idx_nx = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);

  // On the wrapping tick the display register is being reloaded, so the
  // outputs for digit 0 must come from the shadow it is about to take.
  assign w_src_data = w_wrap ? r_sh_data : r_disp_data;
  assign w_src_dp   = w_wrap ? r_sh_dp   : r_disp_dp;

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    w_blank = '0;
    w_blank[DIGITS-1] = (w_src_data[4*DIGITS-1 -: 4] == 4'h0)
                        && !w_src_dp[DIGITS-1];
    for (int i = DIGITS - 2; i >= 1; i--) begin
      w_blank[i] = w_blank[i+1]
                   && (w_src_data[4*i +: 4] == 4'h0)
                   && !w_src_dp[i];
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_one       = {{(DIGITS-1){1'b0}}, 1'b1};
  assign w_nib       = w_src_data[{w_idx_nx, 2'b00} +: 4];
  assign w_sel_blank = w_blank[w_idx_nx];
  assign w_sel_dp    = w_src_dp[w_idx_nx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= IDX_LAST;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_idx <= w_idx_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_data   <= '0;
      r_sh_dp     <= '0;
      r_disp_data <= '0;
      r_disp_dp   <= '0;
    end else begin
      if (w_wrap) begin
        r_disp_data <= r_sh_data;
        r_disp_dp   <= r_sh_dp;
      end
      if (load) begin
        r_sh_data <= data_in;
        r_sh_dp   <= dp_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nib        <= 4'h0;
      r_an_n       <= '1;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_nib  <= w_nib;
        r_an_n <= w_sel_blank ? '1 : ~(w_one << w_idx_nx);
        r_dp_n <= w_sel_blank | ~w_sel_dp;
      end
    end
  end

  assign nibble_out = r_nib;
  assign an_n       = r_an_n;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: frame-position model plus pinned literals.
module tb_display_scan_driver;
  localparam int D = 4;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  nibble_out;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scan_driver #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .nibble_out (nibble_out),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  // k = clock edges since reset release
  int k = 0;
  logic [15:0] m_sh, m_disp;
  logic [3:0]  m_shdp, m_dispdp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  function automatic bit m_blank(input int i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i == 0) return 1'b0;
    for (int j = i; j < D; j++)
      if (m_disp[4*j +: 4] != 4'h0 || m_dispdp[j]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_model();
    int n;
    int idx;
    logic [3:0] en, ean, one;
    logic edp, efd;
    n = k / P;
    one = 4'b0001;
    if (n == 0) begin
      en = 4'h0; ean = 4'hF; edp = 1'b1; efd = 1'b0;
    end else begin
      idx = (n - 1) % D;
      en  = m_disp[4*idx +: 4];
      if (m_blank(idx)) begin
        ean = 4'hF; edp = 1'b1;
      end else begin
        ean = ~(one << idx);
        edp = ~m_dispdp[idx];
      end
      efd = ((k % (D*P)) == P);
    end
    chk("m_nibble", nibble_out, en);
    chk("m_an_n", an_n, ean);
    chk("m_dp_n", dp_n, edp);
    chk("m_frame_done", frame_done, efd);
  endtask

  task automatic step(input logic ld, input logic [15:0] d,
                      input logic [3:0] p);
    load = ld; data_in = d; dp_in = p;
    @(posedge clk);
    k++;
    if ((k % (D*P)) == P) begin
      m_disp = m_sh; m_dispdp = m_shdp;
    end
    if (ld) begin
      m_sh = d; m_shdp = p;
    end
    @(negedge clk);
    load = 1'b0;
    check_model();
  endtask

  task automatic idle_to(input int target);
    while (k < target) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic model_reset();
    k = 0; m_sh = '0; m_disp = '0; m_shdp = '0; m_dispdp = '0;
  endtask

  initial begin
    logic [15:0] rd;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_an_n", an_n, 4'hF);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_nib", nibble_out, 4'h0);
    reset = 1'b0;
    check_model();

    idle_to(3);  chk("pre_tick_an", an_n, 4'hF);
    idle_to(4);  chk("first_an", an_n, 4'b1110);
    chk("first_fd", frame_done, 1'b1);
    idle_to(5);  chk("fd_one_cycle", frame_done, 1'b0);
    idle_to(8);  chk("an_d1", an_n, 4'b1101);
    idle_to(12); chk("an_d2", an_n, 4'b1011);
    idle_to(16); chk("an_d3", an_n, 4'b0111);
    idle_to(20); chk("fd_period", frame_done, 1'b1);

    idle_to(22);
    step(1'b1, 16'h1A2F, 4'b0100);
    idle_to(35); chk("no_tear", nibble_out, 4'h0);
    idle_to(36); chk("nib_d0", nibble_out, 4'hF);
    chk("dp_d0", dp_n, 1'b1);
    idle_to(40); chk("nib_d1", nibble_out, 4'h2);
    idle_to(44); chk("nib_d2", nibble_out, 4'hA);
    chk("dp_d2", dp_n, 1'b0);
    idle_to(48); chk("nib_d3", nibble_out, 4'h1);
    chk("dp_d3", dp_n, 1'b1);

    idle_to(51);
    step(1'b1, 16'h5555, 4'h0);
    chk("wrap_load_old", nibble_out, 4'hF);
    idle_to(68); chk("wrap_load_new", nibble_out, 4'h5);

    idle_to(77); chk("pre_rst_an", an_n, 4'b1011);
    #2 reset = 1'b1;
    #1;
    chk("async_an_n", an_n, 4'hF);
    chk("async_dp_n", dp_n, 1'b1);
    chk("async_fd", frame_done, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    model_reset();
    check_model();
    idle_to(3);  chk("restart_dark", an_n, 4'hF);
    idle_to(4);  chk("restart_an", an_n, 4'b1110);

    idle_to(6);
    step(1'b1, 16'h0030, 4'h0);
    idle_to(24); chk("lz_d1_nib", nibble_out, 4'h3);
    chk("lz_d1_an", an_n, 4'b1101);
    idle_to(28);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d2_an", an_n, 4'hF);
`else
    chk("lz_d2_an", an_n, 4'b1011);
`endif
    idle_to(34);
    step(1'b1, 16'h0000, 4'b1000);
    idle_to(44); chk("dp_keep_d2", an_n, 4'b1011);
    idle_to(48); chk("dp_keep_d3", an_n, 4'b0111);
    chk("dp_keep_dp", dp_n, 1'b0);

    for (int i = 0; i < 800; i++) begin
      rd = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rd = rd & 16'h00FF;
        1: rd = rd & 16'h000F;
        2: rd = 16'h0000;
        default: ;
      endcase
      step(($urandom_range(0, 7) == 0), rd,
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
